wb_writeback_unit: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline register: takes the registered result bundle and commits it to the architectural state. Holds the 32×32 general-purpose register file, the HI and LO registers, a retired-instruction counter and a RUN/HALT state for syscall. Sits at the end of the pipeline. Supplies the decode stage's two asynchronous read ports and the HI/LO read values.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_writeback_unit_if.sv | 43 ++++
 rtl/wb_gpr_array.sv | 57 +++++
 rtl/wb_writeback_unit.sv | 99 +++++++++
 tb/tb_wb_writeback_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: defaults, syscall encoding, FSM states.
// Build option: define WB_BYPASS_EN for write-first GPR reads.
package wb_pkg;

  localparam int NREG_D = 32;
  localparam int DW_D   = 32;
  localparam int AW     = 5;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

  typedef enum logic {
    WB_RUN,
    WB_HALT
  } wb_state_t;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB result bundle presented to the writeback stage.
// Build option: WB_BYPASS_EN affects the consumer only, not this bundle.
interface wb_writeback_unit_if
  import wb_pkg::*;
#(
  parameter int DW = DW_D
);

  logic          wb_valid;
  logic [31:0]   wb_ir;
  logic [31:0]   wb_pc;
  logic [DW-1:0] wb_r1;
  logic [DW-1:0] wb_r2;
  logic [AW-1:0] wb_regnum;
  logic          wb_regwrite;
  logic          wb_lowrite;
  logic          wb_hiwrite;

  modport master (
    output wb_valid,
    output wb_ir,
    output wb_pc,
    output wb_r1,
    output wb_r2,
    output wb_regnum,
    output wb_regwrite,
    output wb_lowrite,
    output wb_hiwrite
  );

  modport slave (
    input wb_valid,
    input wb_ir,
    input wb_pc,
    input wb_r1,
    input wb_r2,
    input wb_regnum,
    input wb_regwrite,
    input wb_lowrite,
    input wb_hiwrite
  );

endinterface

// File: rtl/wb_gpr_array.sv
// General-purpose register file: one sync write port, two async read ports.
// Build option: WB_BYPASS_EN returns the pending write data on a matching read.
module wb_gpr_array
  import wb_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int DW   = DW_D
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef WB_BYPASS_EN
  logic hit_a;
  logic hit_b;

  assign hit_a = we && (waddr == raddr_a);
  assign hit_b = we && (waddr == raddr_b);

  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
    if (hit_a) rdata_a = wdata;
    if (hit_b) rdata_b = wdata;
    // Index 0 wins over any bypass match.
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end
`else
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end
`endif

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: commits MEM/WB bundles to GPRs, HI/LO, counters, RUN/HALT.
// Build option: WB_BYPASS_EN enables write-first GPR read ports.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int DW   = DW_D
) (
  input  logic                 clk,
  input  logic                 CLR,
  wb_writeback_unit_if.slave   wb,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rt_addr,
  output logic [DW-1:0]        rs_data,
  output logic [DW-1:0]        rt_data,
  output logic [DW-1:0]        hi_data,
  output logic [DW-1:0]        lo_data,
  output logic [31:0]          retired,
  output logic [31:0]          last_pc,
  output logic                 halted
);

  wb_state_t state;
  wb_state_t state_nx;

  logic is_syscall;
  logic commit;
  logic gpr_we;
  logic lo_we;
  logic hi_we;

  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  assign is_syscall = (wb.wb_ir == SYSCALL_WORD);
  assign commit     = wb.wb_valid && (state == WB_RUN);

  // A syscall retires but never updates architectural data.
  assign gpr_we = commit && wb.wb_regwrite
                  && (wb.wb_regnum != '0) && !is_syscall;
  assign lo_we  = commit && wb.wb_lowrite && !is_syscall;
  assign hi_we  = commit && wb.wb_hiwrite && !is_syscall;

  wb_gpr_array #(
    .NREG (NREG),
    .DW   (DW)
  ) u_gpr (
    .clk     (clk),
    .clr     (CLR),
    .we      (gpr_we),
    .waddr   (wb.wb_regnum),
    .wdata   (wb.wb_r1),
    .raddr_a (rs_addr),
    .rdata_a (rs_data),
    .raddr_b (rt_addr),
    .rdata_b (rt_data)
  );

  always_ff @(posedge clk) begin
    if (CLR) begin
      hi_q    <= '0;
      lo_q    <= '0;
      retired <= '0;
      last_pc <= '0;
    end else begin
      if (hi_we) hi_q <= wb.wb_r2;
      if (lo_we) lo_q <= wb.wb_r1;
      if (commit) begin
        retired <= retired + 32'd1;
        last_pc <= wb.wb_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) state <= WB_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WB_RUN: begin
        if (commit && is_syscall) state_nx = WB_HALT;
      end
      WB_HALT: begin
        state_nx = WB_HALT;
      end
      default: begin
        state_nx = WB_RUN;
      end
    endcase
  end

  assign hi_data = hi_q;
  assign lo_data = lo_q;
  assign halted  = (state == WB_HALT);

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit against an architectural model.
// Build option: WB_BYPASS_EN switches the expected same-cycle read behaviour.
module tb_wb_writeback_unit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        CLR;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [31:0] retired;
  logic [31:0] last_pc;
  logic        halted;

  wb_writeback_unit_if bus ();

  wb_writeback_unit dut (
    .clk     (clk),
    .CLR     (CLR),
    .wb      (bus),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_data (hi_data),
    .lo_data (lo_data),
    .retired (retired),
    .last_pc (last_pc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ret;
    logic [31:0] pc;
    logic        h;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_ret;
  logic [31:0] m_pc;
  bit          m_halt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_hi = 0; m_lo = 0; m_ret = 0; m_pc = 0; m_halt = 0;
  endtask

  // What a decode read should see while this bundle sits before the edge.
  function automatic logic [31:0] m_read(input logic [4:0] a, input bit v,
      input logic [31:0] ir, input logic [4:0] rn, input bit rw,
      input logic [31:0] r1);
    if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (v && !m_halt && rw && rn == a && ir != 32'hC) return r1;
`endif
    return m_reg[a];
  endfunction

  task automatic step(input bit clr, input bit v, input logic [31:0] ir,
      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
      input logic [4:0] rn, input bit rw, input bit lw, input bit hw,
      input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    @(negedge clk);
    CLR = clr;
    bus.wb_valid = v; bus.wb_ir = ir; bus.wb_pc = pc;
    bus.wb_r1 = r1; bus.wb_r2 = r2; bus.wb_regnum = rn;
    bus.wb_regwrite = rw; bus.wb_lowrite = lw; bus.wb_hiwrite = hw;
    rs_addr = ra; rt_addr = rb;
    e.rs = m_read(ra, v, ir, rn, rw, r1);
    e.rt = m_read(rb, v, ir, rn, rw, r1);
    e.hi = m_hi; e.lo = m_lo; e.ret = m_ret; e.pc = m_pc; e.h = m_halt;
    q.push_back(e);
    if (clr) begin
      model_clear();
    end else if (v && !m_halt) begin
      m_ret = m_ret + 1;
      m_pc = pc;
      if (ir == 32'hC) begin
        m_halt = 1;
      end else begin
        if (rw && rn != 0) m_reg[rn] = r1;
        if (lw) m_lo = r1;
        if (hw) m_hi = r2;
      end
    end
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, ra, rb);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rs_data", rs_data, e.rs);
        chk("rt_data", rt_data, e.rt);
        chk("hi_data", hi_data, e.hi);
        chk("lo_data", lo_data, e.lo);
        chk("retired", retired, e.ret);
        chk("last_pc", last_pc, e.pc);
        chk("halted", {31'h0, halted}, {31'h0, e.h});
      end
    end
  end

  initial begin
    CLR = 1;
    bus.wb_valid = 0; bus.wb_ir = 0; bus.wb_pc = 0;
    bus.wb_r1 = 0; bus.wb_r2 = 0; bus.wb_regnum = 0;
    bus.wb_regwrite = 0; bus.wb_lowrite = 0; bus.wb_hiwrite = 0;
    rs_addr = 0; rt_addr = 0;
    repeat (2) @(posedge clk);
    model_clear();

    idle(5'd1, 5'd31);
    step(0, 1, 32'h0, 32'h400, 32'hDEADBEEF, 32'h0, 5'd5, 1, 0, 0, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    step(0, 1, 32'h0, 32'h404, 32'h1234, 32'h0, 5'd0, 1, 0, 0, 5'd0, 5'd0);
    idle(5'd0, 5'd5);
    step(0, 1, 32'h0, 32'h408, 32'h11, 32'h22, 5'd0, 0, 1, 1, 5'd0, 5'd0);
    step(0, 0, 32'h0, 32'h40C, 32'h99, 32'h88, 5'd6, 1, 1, 1, 5'd6, 5'd0);
    idle(5'd6, 5'd5);
    step(0, 1, 32'h0, 32'h410, 32'hA5A5A5A5, 32'h0, 5'd3, 1, 0, 0, 5'd0, 5'd3);
    idle(5'd0, 5'd3);
    step(0, 1, 32'hC, 32'h500, 32'h77, 32'h66, 5'd9, 1, 1, 1, 5'd9, 5'd9);
    step(0, 1, 32'h0, 32'h504, 32'h7777, 32'h0, 5'd7, 1, 0, 0, 5'd7, 5'd9);
    idle(5'd7, 5'd5);
    step(1, 1, 32'h0, 32'h508, 32'h55, 32'h0, 5'd8, 1, 1, 1, 5'd8, 5'd5);
    idle(5'd8, 5'd5);
    idle(5'd3, 5'd5);

    for (int n = 0; n < 800; n++) begin
      logic [4:0]  rn;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ir;
      rn = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rn : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rn : 5'($urandom_range(0, 31));
      ir = ($urandom_range(0, 39) == 0) ? 32'hC : $urandom;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, ir,
           $urandom, $urandom, $urandom, rn,
           1'($urandom), 1'($urandom), 1'($urandom), ra, rb);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
